// File: rtl/uart_txbuf.sv
// CPU-facing transmit FIFO that drains bytes one at a time into a downstream UART core.
// Optional drained-interrupt logic is built when UART_TXBUF_IRQ_EN is defined.
module uart_txbuf #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  a,
  input  logic [31:0] d,
  input  logic        we,
  output logic [31:0] spo,
  output logic [2:0]  u_a,
  output logic [31:0] u_d,
  output logic        u_we,
  input  logic [31:0] u_spo,
  output logic        irq
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [2:0] UA_STATUS = 3'b010;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GUARD, S_WAIT_IDLE} state_t;

  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wptr, r_rptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_ovf;
  state_t                r_state, w_state_nxt;
  logic [2:0]            r_ua, w_ua_nxt;
  logic [31:0]           r_ud, w_ud_nxt;
  logic                  r_uwe, w_uwe_nxt;

  logic w_uart_idle, w_full, w_push, w_pop, w_push_ok, w_ovf_set, w_ovf_clr, w_done;
  logic [7:0]  w_cnt8;
  logic [31:0] w_spo;
  logic        w_unused_bits;

  assign w_uart_idle = u_spo[24];
  assign w_full      = (r_count == CNT_FULL);
  assign w_pop       = (r_state == S_IDLE) && (r_count != '0) && w_uart_idle;
  assign w_push      = we && (a == 3'd0);
  // A full FIFO still takes a byte when the drain pops in the same cycle.
  assign w_push_ok   = w_push && (!w_full || w_pop);
  assign w_ovf_set   = w_push && !w_push_ok;
  assign w_ovf_clr   = we && (a == 3'd3);
  assign w_done      = (r_count == '0) && (r_state == S_IDLE) && w_uart_idle;
  assign w_cnt8      = 8'(r_count);

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr] <= d[31:24];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop)     r_rptr <= r_rptr + 1'b1;
      if (w_push_ok && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push_ok && w_pop) r_count <= r_count - 1'b1;
      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (w_ovf_clr) r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ua    <= UA_STATUS;
      r_ud    <= '0;
      r_uwe   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ua    <= w_ua_nxt;
      r_ud    <= w_ud_nxt;
      r_uwe   <= w_uwe_nxt;
    end
  end

  // u_we defaults low so every handoff is a single-cycle pulse.
  always_comb begin
    w_state_nxt = r_state;
    w_ua_nxt    = r_ua;
    w_ud_nxt    = r_ud;
    w_uwe_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ua_nxt = UA_STATUS;
        if (w_pop) begin
          w_ua_nxt    = 3'd0;
          w_ud_nxt    = {r_mem[r_rptr], 24'b0};
          w_uwe_nxt   = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_ua_nxt    = UA_STATUS;
        w_state_nxt = S_GUARD;
      end
      // The core's status is stale for one cycle after a write.
      S_GUARD:     w_state_nxt = S_WAIT_IDLE;
      S_WAIT_IDLE: if (w_uart_idle) w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  assign u_a  = r_ua;
  assign u_d  = r_ud;
  assign u_we = r_uwe;

`ifdef UART_TXBUF_IRQ_EN
  logic r_ie, r_irq;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ie  <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      if (we && (a == 3'd4)) r_ie <= d[24];
      r_irq <= r_ie && w_done;
    end
  end

  assign irq = r_irq;
  assign w_unused_bits = ^{d[23:0], u_spo[31:25], u_spo[23:0]};
`else
  assign irq = 1'b0;
  assign w_unused_bits = ^{d[23:0], u_spo[31:25], u_spo[23:0]};
`endif

  always_comb begin
    w_spo = '0;
    case (a)
      3'd0: w_spo[24]    = w_full;
      3'd1: w_spo[24]    = w_done;
      3'd2: w_spo[31:24] = w_cnt8;
      3'd3: w_spo[24]    = r_ovf;
`ifdef UART_TXBUF_IRQ_EN
      3'd4: w_spo[24]    = r_ie;
`endif
      default: w_spo = '0;
    endcase
  end

  assign spo = w_spo;

endmodule

// File: tb/tb_uart_txbuf.sv
// Self-checking bench for uart_txbuf: register vectors, drain corner cases and a
// randomized run against a queue-based model with a busy-counter UART core stand-in.
module tb_uart_txbuf;
  localparam int DL2   = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0, rst = 1'b1;
  logic [2:0] a = '0;
  logic [31:0] d = '0;
  logic we = 1'b0;
  logic [31:0] spo, u_d, u_spo;
  logic [2:0] u_a;
  logic u_we, irq;

  always #5 clk = ~clk;

  uart_txbuf #(.DEPTH_LOG2(DL2)) dut (
    .clk(clk), .rst(rst), .a(a), .d(d), .we(we), .spo(spo),
    .u_a(u_a), .u_d(u_d), .u_we(u_we), .u_spo(u_spo), .irq(irq)
  );

  // UART core stand-in: busy for busy_len cycles after each data write.
  int busy = 0;
  int busy_len = 3;
  bit force_busy = 1'b0;
  always @(posedge clk) begin
    if (rst) busy <= 0;
    else if (u_we && u_a == 3'd0) busy <= busy_len;
    else if (busy > 0) busy <= busy - 1;
  end
  assign u_spo = {7'b0, (busy == 0 && !force_busy), 24'b0};

  typedef struct {
    logic [7:0] b;
    logic [2:0] ua;
    int         cyc;
    bit         idle_b;
    bit         we_b;
  } pulse_t;

  pulse_t got_q[$];
  int cyc = 0;
  bit idle_at_neg = 1'b1;
  bit last_we = 1'b0;

  always @(negedge clk) idle_at_neg = u_spo[24];
  always @(posedge clk) begin
    #1;
    cyc++;
    if (u_we) got_q.push_back('{u_d[31:24], u_a, cyc, idle_at_neg, last_we});
    last_we = u_we;
  end

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [2:0] aa, input logic [31:0] dd);
    a = aa; d = dd; we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic rd(input logic [2:0] aa, output logic [31:0] v);
    a = aa;
    #1;
    v = spo;
  endtask

  task automatic do_reset();
    rst = 1'b1; we = 1'b0; a = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic wait_pulses(input int n, input int budget, input string nm);
    int k = 0;
    while (got_q.size() < n && k < budget) begin tick(); k++; end
    chk({nm, " pulses seen"}, 32'(got_q.size() >= n), 32'd1);
  endtask

  task automatic wait_done(input int budget, input string nm);
    logic [31:0] v;
    int k = 0;
    rd(3'd1, v);
    while (!v[24] && k < budget) begin tick(); rd(3'd1, v); k++; end
    chk({nm, " done"}, v, 32'h0100_0000);
  endtask

  // Byte, core register select, core idle beforehand, and no strobe the cycle before.
  task automatic chk_pulse(input string nm, input logic [7:0] eb);
    pulse_t p;
    if (got_q.size() == 0) begin
      chk({nm, " pulse present"}, 32'd0, 32'd1);
    end else begin
      p = got_q.pop_front();
      chk(nm, {p.b, 5'b0, p.ua, 7'b0, p.idle_b, 7'b0, p.we_b}, {eb, 8'h00, 8'h01, 8'h00});
    end
  endtask

  typedef struct {
    bit          w;
    logic [2:0]  wa;
    logic [31:0] wd;
    logic [2:0]  ra;
    logic [31:0] exp;
  } vec_t;

  initial begin
    vec_t tv[$];
    logic [31:0] v;
    logic [7:0] exp_q[$];
    logic [7:0] b;
    pulse_t p0, p1, p2;
    int occ;

    // Reset state
    do_reset();
    chk("rst u_a", {29'b0, u_a}, 32'd2);
    chk("rst u_we", {31'b0, u_we}, 32'd0);
    chk("rst u_d", u_d, 32'd0);
    chk("rst irq", {31'b0, irq}, 32'd0);
    rd(3'd0, v); chk("rst full", v, 32'd0);
    rd(3'd1, v); chk("rst done", v, 32'h0100_0000);
    rd(3'd2, v); chk("rst count", v, 32'd0);
    rd(3'd3, v); chk("rst ovf", v, 32'd0);
    rd(3'd7, v); chk("rst a7", v, 32'd0);

    // Single-byte latency: strobe appears after the edge following the push edge
    busy_len = 3;
    a = 3'd0; d = 32'h4100_0000; we = 1'b1;
    tick();
    we = 1'b0;
    chk("lat u_we after E", {31'b0, u_we}, 32'd0);
    tick();
    chk("lat u_we after E+1", {31'b0, u_we}, 32'd1);
    chk("lat u_d", u_d, 32'h4100_0000);
    chk("lat u_a", {29'b0, u_a}, 32'd0);
    rd(3'd2, v); chk("lat count", v, 32'd0);
    tick();
    chk("lat u_we one cycle", {31'b0, u_we}, 32'd0);
    chk_pulse("lat byte", 8'h41);
    wait_done(50, "lat");

    // Register vectors with the core held busy: fill, overflow, clear
    force_busy = 1'b1;
    tick();
    tv.push_back('{1'b0, 3'd0, 32'h0,          3'd2, 32'h0000_0000});
    tv.push_back('{1'b0, 3'd0, 32'h0,          3'd1, 32'h0000_0000});
    tv.push_back('{1'b0, 3'd0, 32'h0,          3'd3, 32'h0000_0000});
    tv.push_back('{1'b0, 3'd0, 32'h0,          3'd4, 32'h0000_0000});
    tv.push_back('{1'b0, 3'd0, 32'h0,          3'd5, 32'h0000_0000});
    tv.push_back('{1'b1, 3'd0, 32'h1100_0000,  3'd2, 32'h0100_0000});
    tv.push_back('{1'b1, 3'd0, 32'h1200_0000,  3'd2, 32'h0200_0000});
    tv.push_back('{1'b1, 3'd0, 32'h1300_0000,  3'd0, 32'h0000_0000});
    tv.push_back('{1'b1, 3'd0, 32'h1400_0000,  3'd0, 32'h0100_0000});
    tv.push_back('{1'b0, 3'd0, 32'h0,          3'd2, 32'h0400_0000});
    tv.push_back('{1'b1, 3'd0, 32'h1500_0000,  3'd3, 32'h0100_0000});
    tv.push_back('{1'b0, 3'd0, 32'h0,          3'd2, 32'h0400_0000});
    tv.push_back('{1'b1, 3'd3, 32'h0,          3'd3, 32'h0000_0000});
    tv.push_back('{1'b0, 3'd0, 32'h0,          3'd0, 32'h0100_0000});
    foreach (tv[i]) begin
      if (tv[i].w) wr(tv[i].wa, tv[i].wd);
      rd(tv[i].ra, v);
      chk($sformatf("vec%0d", i), v, tv[i].exp);
    end
    chk("vec no strobe while busy", 32'(got_q.size()), 32'd0);
    force_busy = 1'b0;
    wait_pulses(4, 200, "fill");
    chk_pulse("fill b0", 8'h11);
    chk_pulse("fill b1", 8'h12);
    chk_pulse("fill b2", 8'h13);
    chk_pulse("fill b3", 8'h14);
    wait_done(100, "fill");
    repeat (10) tick();
    chk("fill dropped byte absent", 32'(got_q.size()), 32'd0);

    // Push into a full FIFO in the same cycle the drain pops
    force_busy = 1'b1;
    wr(3'd0, 32'h2100_0000); wr(3'd0, 32'h2200_0000);
    wr(3'd0, 32'h2300_0000); wr(3'd0, 32'h2400_0000);
    force_busy = 1'b0;
    wr(3'd0, 32'h2500_0000);
    rd(3'd2, v); chk("pushpop count", v, 32'h0400_0000);
    rd(3'd3, v); chk("pushpop ovf", v, 32'd0);
    wait_pulses(5, 300, "pushpop");
    chk_pulse("pushpop b0", 8'h21);
    chk_pulse("pushpop b1", 8'h22);
    chk_pulse("pushpop b2", 8'h23);
    chk_pulse("pushpop b3", 8'h24);
    chk_pulse("pushpop b4", 8'h25);
    wait_done(100, "pushpop");

    // Back-to-back bytes against a slow core
    busy_len = 20;
    wr(3'd0, 32'h0100_0000); wr(3'd0, 32'h0200_0000); wr(3'd0, 32'h0300_0000);
    wait_pulses(3, 400, "slow");
    if (got_q.size() >= 3) begin
      p0 = got_q[0]; p1 = got_q[1]; p2 = got_q[2];
      chk("slow gap01 >= 20", 32'(p1.cyc - p0.cyc >= 20), 32'd1);
      chk("slow gap12 >= 20", 32'(p2.cyc - p1.cyc >= 20), 32'd1);
    end
    chk_pulse("slow b0", 8'h01);
    chk_pulse("slow b1", 8'h02);
    chk_pulse("slow b2", 8'h03);
    wait_done(200, "slow");

    // Reset mid-drain discards the remaining bytes
    busy_len = 5;
    wr(3'd0, 32'h6100_0000); wr(3'd0, 32'h6200_0000); wr(3'd0, 32'h6300_0000);
    wait_pulses(1, 20, "rstmid");
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    rd(3'd2, v); chk("rstmid count", v, 32'd0);
    chk("rstmid u_a", {29'b0, u_a}, 32'd2);
    repeat (40) tick();
    chk("rstmid strobes", 32'(got_q.size()), 32'd1);
    chk_pulse("rstmid b0", 8'h61);

    // Drained interrupt
    busy_len = 4;
`ifdef UART_TXBUF_IRQ_EN
    wr(3'd4, 32'h0100_0000);
    rd(3'd4, v); chk("irq enable rd", v, 32'h0100_0000);
    tick();
    chk("irq idle high", {31'b0, irq}, 32'd1);
    wr(3'd0, 32'h7100_0000); wr(3'd0, 32'h7200_0000);
    chk("irq low after push", {31'b0, irq}, 32'd0);
    wait_pulses(2, 100, "irq");
    chk("irq low during drain", {31'b0, irq}, 32'd0);
    wait_done(100, "irq");
    tick();
    chk("irq high after drain", {31'b0, irq}, 32'd1);
    chk_pulse("irq b0", 8'h71);
    chk_pulse("irq b1", 8'h72);
    do_reset();
    chk("irq after rst", {31'b0, irq}, 32'd0);
    rd(3'd2, v); chk("irq rst count", v, 32'd0);
    rd(3'd4, v); chk("irq rst enable", v, 32'd0);
`else
    wr(3'd4, 32'h0100_0000);
    rd(3'd4, v); chk("noirq a4 rd", v, 32'd0);
    wr(3'd0, 32'h7100_0000);
    wait_pulses(1, 50, "noirq");
    wait_done(100, "noirq");
    tick();
    chk("noirq irq", {31'b0, irq}, 32'd0);
    chk_pulse("noirq b0", 8'h71);
`endif

    // Randomized traffic against a queue model
    got_q.delete();
    for (int i = 0; i < 400; i++) begin
      busy_len = $urandom_range(0, 6);
      occ = exp_q.size() - got_q.size();
      if ($urandom_range(0, 1) == 1 && occ < DEPTH) begin
        b = 8'($urandom);
        exp_q.push_back(b);
        wr(3'd0, {b, 24'h0});
      end else begin
        rd(3'd2, v);
        chk($sformatf("rand count %0d", i), v, {8'(occ), 24'h0});
        tick();
      end
    end
    wait_pulses(exp_q.size(), 2000, "rand");
    chk("rand strobe total", 32'(got_q.size()), 32'(exp_q.size()));
    foreach (exp_q[i]) chk_pulse($sformatf("rand byte %0d", i), exp_q[i]);
    rd(3'd3, v); chk("rand ovf", v, 32'd0);
    wait_done(100, "rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/uart_txbuf.md
UART_TXBUF -- requirements
Module: uart_txbuf

Interface
REQ-001 Parameter: DEPTH_LOG2, default 4, FIFO depth = 2**DEPTH_LOG2 bytes.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 a  input  3  CPU register select.
REQ-005 d  input  32  CPU write data; byte in d[31:24].
REQ-006 we  input  1  CPU write strobe, single cycle.
REQ-007 spo  output  32  CPU read data, combinational on a; flag/value in bits [31:24], bits [23:0] zero.
REQ-008 u_a  output  3  register select to downstream UART core, registered.
REQ-009 u_d  output  32  write data to UART core, byte in [31:24], registered.
REQ-010 u_we  output  1  write strobe to UART core, registered.
REQ-011 u_spo  input  32  UART core read data; u_spo[24] = transmitter idle when u_a = 3'b010.
REQ-012 irq  output  1  drained interrupt, level.

Function
REQ-013 Write a=0: push d[31:24]; accepted if count < DEPTH, or if a pop occurs in the same cycle; otherwise dropped and overflow sticky set.
REQ-014 Read a=0: bit24 = full; a=1: bit24 = done (count==0, FSM IDLE, u_spo[24]==1); a=2: bits[31:24] = count (zero-extended); a=3: bit24 = overflow; others: 0.
REQ-015 Write a=3 clears overflow; a clear and an overflow in the same cycle leave overflow set.
REQ-016 FIFO: circular, write/read pointers wrap modulo DEPTH; count width DEPTH_LOG2+1; simultaneous push and pop leaves count unchanged.
REQ-017 Drain FSM states: IDLE, ISSUE, GUARD, WAIT_IDLE.
REQ-018 IDLE: u_a=3'b010, u_we=0; if count>0 and u_spo[24]==1, register u_a=0, u_d={head,24'b0}, u_we=1, pop head, go ISSUE.
REQ-019 ISSUE: u_we held exactly one cycle; register u_we=0, u_a=3'b010, go GUARD.
REQ-020 GUARD: one cycle, u_spo ignored, go WAIT_IDLE.
REQ-021 WAIT_IDLE: stay until u_spo[24]==1, then go IDLE.
REQ-022 Latency: byte pushed at edge E into empty FIFO with UART idle → u_we high in the cycle following edge E+1.
REQ-023 Back-to-back bytes: exactly one u_we pulse per byte; no second u_we before UART reports idle after GUARD.
REQ-024 CPU writes during drain never stall; spo reads have no side effects.

Reset
REQ-025 On rst: pointers, count, overflow = 0; FSM = IDLE; u_a = 3'b010; u_d = 0; u_we = 0; irq = 0; interrupt enable = 0; FIFO storage not cleared.
REQ-026 rst asserted mid-drain: pending bytes discarded; a byte already handed to the UART is not recalled.

Configuration
REQ-027 Macro UART_TXBUF_IRQ_EN defined: write a=4 loads interrupt enable from d[24]; read a=4 bit24 = enable; irq registered, high while enable & done, low one cycle after done drops.
REQ-028 Macro undefined: irq constant 0; write a=4 ignored; read a=4 returns 0.

Verification
REQ-029 Push 0x41 with UART model idle → u_we=1, u_d=0x41000000, u_a=0 one cycle after edge E+1; count returns to 0.
REQ-030 Push 0x01..0x03 back-to-back; UART model busy 20 cycles per byte → three u_we pulses, bytes in order, each ≥20 cycles apart.
REQ-031 DEPTH_LOG2=2, UART held busy, push 5 bytes → full=1, count=4, overflow=1, fifth byte absent from output; write a=3 → overflow=0.
REQ-032 Full FIFO, UART goes idle, push in same cycle as pop → push accepted, count stays 4, no overflow.
REQ-033 With UART_TXBUF_IRQ_EN, enable=1, push 2 bytes → irq low during drain, high after last byte completes; rst → irq=0, count=0.
REQ-034 Push 3 bytes, assert rst after first u_we → no further u_we, count=0, u_a=3'b010.
